// File: rtl/chord_pkg.sv
// Purpose : shared widths, 12.20 angle constants and the output record for the CORDIC interface blocks.
// Latency : n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package chord_pkg;

    localparam int UNSIGNED_OUTPUT_WIDTH      = 16;
    localparam int UNSIGNED_OUTPUT_INT_WIDTH  = 7;
    localparam int UNSIGNED_OUTPUT_FRAC_WIDTH = 8;
    localparam int ITERATION_WORD_WIDTH       = 32;
    localparam int ITERATION_WORD_INT_WIDTH   = 12;
    localparam int ITERATION_WORD_FRAC_WIDTH  = 20;
    localparam int SECTOR_FLAG_WIDTH          = 2;
    localparam int FIFO_DEPTH                 = 4;

    // Two guard bits so in_z + 3*HALF_PI cannot wrap before the PI comparison.
    localparam int ANGLE_WIDTH = ITERATION_WORD_WIDTH + 2;

    localparam logic [ANGLE_WIDTH-1:0] PI      = ANGLE_WIDTH'(3294199);
    localparam logic [ANGLE_WIDTH-1:0] HALF_PI = ANGLE_WIDTH'(1647099);
    localparam logic [ANGLE_WIDTH-1:0] TWO_PI  = ANGLE_WIDTH'(6588398);

    localparam int ROUND_SHIFT = ITERATION_WORD_FRAC_WIDTH - UNSIGNED_OUTPUT_FRAC_WIDTH;
    localparam logic [ANGLE_WIDTH:0] ROUND_HALF = (ANGLE_WIDTH+1)'(1) << (ROUND_SHIFT - 1);
    localparam logic [ANGLE_WIDTH:0] MAG_MAX    = (ANGLE_WIDTH+1)'(2**(UNSIGNED_OUTPUT_WIDTH-1) - 1);

    typedef struct packed {
        logic                             sat;
        logic [UNSIGNED_OUTPUT_WIDTH-1:0] magnitude;
        logic [UNSIGNED_OUTPUT_WIDTH-1:0] angle;
    } out_rec_t;

    // Returns {sat, sign-magnitude word}. Rounds half up on the magnitude;
    // a zero result never carries the sign so -0 cannot appear.
    function automatic logic [UNSIGNED_OUTPUT_WIDTH:0] round_sat(input logic sign,
                                                                 input logic [ANGLE_WIDTH-1:0] mag);
        logic [ANGLE_WIDTH:0] rounded;
        rounded = ({1'b0, mag} + ROUND_HALF) >> ROUND_SHIFT;
        if (rounded > MAG_MAX)
            return {1'b1, sign, {(UNSIGNED_OUTPUT_WIDTH-1){1'b1}}};
        else
            return {1'b0, sign && (rounded != '0), rounded[UNSIGNED_OUTPUT_WIDTH-2:0]};
    endfunction

endpackage

// File: rtl/interface_output_if.sv
// Purpose : bundles the pipeline-result inputs and the consumer valid/ready outputs of interface_output.
// Latency : n/a (wiring only).
// Backpressure: out_ready from the consumer; the pipeline side has none.
// Ports   : in_valid/in_x/in_z/in_sector (pipeline -> block), out_valid/out_ready/out_magnitude/
//           out_angle/out_sat (block <-> consumer), overflow_err (sticky status).
interface interface_output_if;
    import chord_pkg::*;

    logic                                 in_valid;
    logic [ITERATION_WORD_WIDTH-1:0]      in_x;
    logic [ITERATION_WORD_WIDTH-1:0]      in_z;
    logic [SECTOR_FLAG_WIDTH-1:0]         in_sector;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [UNSIGNED_OUTPUT_WIDTH-1:0]     out_magnitude;
    logic [UNSIGNED_OUTPUT_WIDTH-1:0]     out_angle;
    logic                                 out_sat;
    logic                                 overflow_err;

    // master: the conversion block itself.
    modport master (
        input  in_valid, in_x, in_z, in_sector, out_ready,
        output out_valid, out_magnitude, out_angle, out_sat, overflow_err
    );

    // slave: pipeline driver plus result consumer.
    modport slave (
        output in_valid, in_x, in_z, in_sector, out_ready,
        input  out_valid, out_magnitude, out_angle, out_sat, overflow_err
    );

endinterface

// File: rtl/output_fifo.sv
// Purpose : generic first-word-fall-through FIFO, head entry visible on o_pop_dat whenever !o_empty.
// Latency : a push is visible at the head the cycle after it is written; no same-cycle bypass.
// Backpressure: push on a full FIFO is ignored unless a pop happens in the same cycle.
// Ports   : clk, rst (sync, active high), i_push/i_push_dat, i_pop, o_pop_dat, o_full, o_empty, o_count.
module output_fifo #(
    parameter  int WIDTH = 33,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_pop_dat = r_mem[r_rd_ptr];

    // A pop frees the slot the simultaneous write lands in, so full+pop still accepts.
    assign w_rd_en = i_pop && !o_empty;
    assign w_wr_en = i_push && (!o_full || w_rd_en);

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr] <= i_push_dat;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/interface_output.sv
// Purpose : sector-corrects the CORDIC angle, rounds/saturates x and angle to 7.8 sign-magnitude, buffers in a FIFO.
// Latency : in_valid sampled at edge N -> out_valid high after edge N+2 (FIFO empty).
// Backpressure: out_ready stalls the FIFO only; pipeline cannot stall, so a full FIFO drops and sets sticky overflow_err.
// Ports   : clk, rst (sync, active high), bus (interface_output_if.master: pipeline inputs, consumer handshake, overflow_err).
module interface_output
    import chord_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    interface_output_if.master bus
);

    localparam int AW = ANGLE_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH);

    // Stage 1 combinational: sector correction and absolute values.
    logic [AW-1:0] w_x_ext;
    logic [AW-1:0] w_z_ext;
    logic [AW-1:0] w_sector_off;
    logic [AW-1:0] w_angle_sum;
    logic [AW-1:0] w_angle_corr;
    logic [AW-1:0] w_x_abs;
    logic [AW-1:0] w_angle_abs;

    assign w_x_ext      = {{(AW-ITERATION_WORD_WIDTH){bus.in_x[ITERATION_WORD_WIDTH-1]}}, bus.in_x};
    assign w_z_ext      = {{(AW-ITERATION_WORD_WIDTH){bus.in_z[ITERATION_WORD_WIDTH-1]}}, bus.in_z};
    assign w_sector_off = AW'(bus.in_sector) * HALF_PI;
    assign w_angle_sum  = w_z_ext + w_sector_off;
    // Fold back into (-PI, PI] after undoing the quadrant pre-rotation.
    assign w_angle_corr = ($signed(w_angle_sum) > $signed(PI)) ? (w_angle_sum - TWO_PI) : w_angle_sum;
    assign w_x_abs      = w_x_ext[AW-1]      ? -w_x_ext      : w_x_ext;
    assign w_angle_abs  = w_angle_corr[AW-1] ? -w_angle_corr : w_angle_corr;

    logic          r_s1_vld;
    logic          r_s1_x_sign;
    logic [AW-1:0] r_s1_x_abs;
    logic          r_s1_a_sign;
    logic [AW-1:0] r_s1_a_abs;

    always_ff @(posedge clk) begin
        if (rst) r_s1_vld <= 1'b0;
        else     r_s1_vld <= bus.in_valid;
    end

    always_ff @(posedge clk) begin
        r_s1_x_sign <= w_x_ext[AW-1];
        r_s1_x_abs  <= w_x_abs;
        r_s1_a_sign <= w_angle_corr[AW-1];
        r_s1_a_abs  <= w_angle_abs;
    end

    // Stage 2: round 20 -> 8 fraction bits and saturate into the 16-bit word.
    logic [UNSIGNED_OUTPUT_WIDTH:0] w_mag_rs;
    logic [UNSIGNED_OUTPUT_WIDTH:0] w_ang_rs;
    out_rec_t                       w_s2_rec;

    assign w_mag_rs = round_sat(r_s1_x_sign, r_s1_x_abs);
    assign w_ang_rs = round_sat(r_s1_a_sign, r_s1_a_abs);

    always_comb begin
        w_s2_rec           = '0;
        w_s2_rec.sat       = w_mag_rs[UNSIGNED_OUTPUT_WIDTH] | w_ang_rs[UNSIGNED_OUTPUT_WIDTH];
        w_s2_rec.magnitude = w_mag_rs[UNSIGNED_OUTPUT_WIDTH-1:0];
        w_s2_rec.angle     = w_ang_rs[UNSIGNED_OUTPUT_WIDTH-1:0];
    end

    logic     r_s2_vld;
    out_rec_t r_s2_rec;

    always_ff @(posedge clk) begin
        if (rst) r_s2_vld <= 1'b0;
        else     r_s2_vld <= r_s1_vld;
    end

    always_ff @(posedge clk) begin
        r_s2_rec <= w_s2_rec;
    end

    // Output buffer.
    out_rec_t  w_fifo_rec;
    logic      w_full;
    logic      w_empty;
    logic [CW:0] w_fifo_count;

    output_fifo #(
        .WIDTH ($bits(out_rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (r_s2_vld),
        .i_push_dat (r_s2_rec),
        .i_pop      (bus.out_ready),
        .o_pop_dat  (w_fifo_rec),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_fifo_count)
    );

    // A full FIFO is never empty, so out_ready alone means a pop frees a slot.
    logic w_drop;
    logic r_overflow_err;

    assign w_drop = r_s2_vld && w_full && !bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst)         r_overflow_err <= 1'b0;
        else if (w_drop) r_overflow_err <= 1'b1;
    end

    // Zero the data outputs when nothing is held so stale or uninitialised entries never show.
    assign bus.out_valid     = (w_fifo_count != '0);
    assign bus.out_magnitude = w_empty ? '0   : w_fifo_rec.magnitude;
    assign bus.out_angle     = w_empty ? '0   : w_fifo_rec.angle;
    assign bus.out_sat       = w_empty ? 1'b0 : w_fifo_rec.sat;
    assign bus.overflow_err  = r_overflow_err;

endmodule
